// File: rtl/pwm_timer_channel.sv
// One timer/PWM channel: prescaler, period counter with period-boundary shadowing,
// registered PWM/timer output and a one-clock interrupt pulse per period wrap.
module pwm_timer_channel #(
  parameter int mem_width = 16
) (
  input  logic                 i_wb_clk,
  input  logic                 i_wb_rst,
  input  logic [mem_width-1:0] i_ctrl,
  input  logic [mem_width-1:0] i_period,
  input  logic [mem_width-1:0] i_divisor,
  input  logic [mem_width-1:0] i_dc,
  output logic                 o_pwm,
  output logic                 o_irq
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [mem_width-1:0] ZERO = {mem_width{1'b0}};
  localparam logic [mem_width-1:0] ONE  = {{(mem_width-1){1'b0}}, 1'b1};

  state_t               state_r, state_nx_s;
  logic [mem_width-1:0] div_cnt_r, cnt_r, per_sh_r, dc_sh_r;
  logic                 en_s, mode_pwm_s, cont_s, irq_en_s, clr_s;
  logic                 tick_s, wrap_s, start_s, pwm_nx_s;
  logic                 unused_ctrl_s;

  assign en_s          = i_ctrl[0];
  assign mode_pwm_s    = i_ctrl[1];
  assign cont_s        = i_ctrl[2];
  assign irq_en_s      = i_ctrl[3];
  assign clr_s         = i_ctrl[7];
  assign unused_ctrl_s = ^{i_ctrl[mem_width-1:8], i_ctrl[6:4]};

  // Prescaler tick and period wrap; the divisor compare uses >= so a live
  // divisor reduction below div_cnt cannot stall the prescaler.
  always_comb begin
    tick_s = 1'b0;
    wrap_s = 1'b0;
    if (state_r == ST_RUN && (i_divisor <= ONE || div_cnt_r >= (i_divisor - ONE))) begin
      tick_s = 1'b1;
    end else begin
      tick_s = 1'b0;
    end
    if (tick_s && !clr_s && cnt_r == (per_sh_r - ONE)) begin
      wrap_s = 1'b1;
    end else begin
      wrap_s = 1'b0;
    end
  end

  // Next-state logic; disable and zero period take priority over counting events.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (en_s && i_period != ZERO && !clr_s) begin
          state_nx_s = ST_RUN;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!en_s || i_period == ZERO || per_sh_r == ZERO) begin
          state_nx_s = ST_IDLE;
        end else if (wrap_s && !mode_pwm_s && !cont_s) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (!en_s || clr_s) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_DONE;
        end
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  assign start_s = (state_r == ST_IDLE) && (state_nx_s == ST_RUN);

  // Next PWM/timer output level, registered below.
  always_comb begin
    pwm_nx_s = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (state_nx_s == ST_IDLE) begin
          pwm_nx_s = 1'b0;
        end else if (mode_pwm_s) begin
          pwm_nx_s = (cnt_r < dc_sh_r);
        end else if (wrap_s) begin
          pwm_nx_s = cont_s ? ~o_pwm : 1'b1;
        end else begin
          pwm_nx_s = o_pwm;
        end
      end
      ST_DONE: begin
        if (state_nx_s == ST_IDLE) begin
          pwm_nx_s = 1'b0;
        end else begin
          pwm_nx_s = o_pwm;
        end
      end
      ST_IDLE: pwm_nx_s = 1'b0;
      default: pwm_nx_s = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Prescaler and main counter; cnt_clr outranks the tick.
  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) begin
      div_cnt_r <= ZERO;
      cnt_r     <= ZERO;
    end else begin
      if (clr_s || state_r != ST_RUN || state_nx_s != ST_RUN || tick_s) begin
        div_cnt_r <= ZERO;
      end else begin
        div_cnt_r <= div_cnt_r + ONE;
      end
      if (clr_s || state_nx_s == ST_IDLE || wrap_s) begin
        cnt_r <= ZERO;
      end else if (tick_s) begin
        cnt_r <= cnt_r + ONE;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // Shadow registers only change at start or at a period boundary.
  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) begin
      per_sh_r <= ZERO;
      dc_sh_r  <= ZERO;
    end else if (start_s || wrap_s) begin
      per_sh_r <= i_period;
      dc_sh_r  <= i_dc;
    end else begin
      per_sh_r <= per_sh_r;
      dc_sh_r  <= dc_sh_r;
    end
  end

  // Registered outputs; a wrap seen together with a zero period raises no irq.
  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) begin
      o_pwm <= 1'b0;
      o_irq <= 1'b0;
    end else begin
      o_pwm <= pwm_nx_s;
      o_irq <= wrap_s && irq_en_s && (i_period != ZERO);
    end
  end

endmodule

// File: tb/tb_pwm_timer_channel.sv
// Directed self-checking bench for pwm_timer_channel with hand-derived waveforms.
module tb_pwm_timer_channel;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ctrl, period, divisor, dc;
  logic        pwm, irq;
  int          errors = 0;
  int          checks = 0;

  pwm_timer_channel #(.mem_width(16)) dut (
    .i_wb_clk (clk),
    .i_wb_rst (rst),
    .i_ctrl   (ctrl),
    .i_period (period),
    .i_divisor(divisor),
    .i_dc     (dc),
    .o_pwm    (pwm),
    .o_irq    (irq)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic go_idle();
    ctrl = 16'h0000;
    step(2);
  endtask

  task automatic test_reset();
    rst = 1'b1; ctrl = 16'h0000; period = 16'd0; divisor = 16'd0; dc = 16'd0;
    step(2);
    checks++; if (pwm !== 1'b0) begin errors++; $display("FAIL reset_pwm: got %b want 0", pwm); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
    rst = 1'b0;
    step(1);
    period = 16'd4; divisor = 16'd1; dc = 16'd4; ctrl = 16'h000B;
    step(4);
    checks++; if (pwm !== 1'b1) begin errors++; $display("FAIL prereset_pwm: got %b want 1", pwm); end
    #2 rst = 1'b1;
    #1;
    checks++; if (pwm !== 1'b0) begin errors++; $display("FAIL async_reset_pwm: got %b want 0", pwm); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL async_reset_irq: got %b want 0", irq); end
    ctrl = 16'h0000;
    rst = 1'b0;
    step(5);
    checks++; if (pwm !== 1'b0 || irq !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle: pwm=%b irq=%b want 0 0", pwm, irq);
    end
  endtask

  task automatic test_pwm_basic(input logic [15:0] div);
    logic exp_pwm, exp_irq;
    go_idle();
    period = 16'd4; divisor = div; dc = 16'd1; ctrl = 16'h000B;
    step(1);
    for (int k = 1; k <= 12; k++) begin
      step(1);
      exp_pwm = (k % 4 == 1);
      exp_irq = (k % 4 == 0);
      checks++; if (pwm !== exp_pwm) begin errors++; $display("FAIL pwm_basic_pwm div=%0d k=%0d: got %b want %b", div, k, pwm, exp_pwm); end
      checks++; if (irq !== exp_irq) begin errors++; $display("FAIL pwm_basic_irq div=%0d k=%0d: got %b want %b", div, k, irq, exp_irq); end
    end
  endtask

  task automatic test_pwm_div3();
    logic exp_pwm;
    go_idle();
    period = 16'd5; divisor = 16'd3; dc = 16'd2; ctrl = 16'h0003;
    step(1);
    for (int k = 1; k <= 60; k++) begin
      step(1);
      exp_pwm = (k <= 45) && ((((k - 1) / 3) % 5) < 2);
      checks++; if (pwm !== exp_pwm) begin errors++; $display("FAIL pwm_div3 k=%0d: got %b want %b", k, pwm, exp_pwm); end
      if (k == 31) dc = 16'd0;
    end
  endtask

  task automatic test_oneshot();
    logic exp_pwm, exp_irq;
    go_idle();
    period = 16'd10; divisor = 16'd2; dc = 16'd0; ctrl = 16'h0009;
    step(1);
    for (int k = 1; k <= 26; k++) begin
      step(1);
      exp_irq = (k == 20);
      exp_pwm = (k >= 20);
      checks++; if (irq !== exp_irq) begin errors++; $display("FAIL oneshot_irq k=%0d: got %b want %b", k, irq, exp_irq); end
      checks++; if (pwm !== exp_pwm) begin errors++; $display("FAIL oneshot_pwm k=%0d: got %b want %b", k, pwm, exp_pwm); end
    end
    ctrl = 16'h0008;
    step(1);
    checks++; if (pwm !== 1'b0) begin errors++; $display("FAIL oneshot_disable_pwm: got %b want 0", pwm); end
  endtask

  task automatic test_timer_cont();
    logic exp_pwm, exp_irq;
    go_idle();
    period = 16'd3; divisor = 16'd1; dc = 16'd0; ctrl = 16'h000D;
    step(1);
    for (int k = 1; k <= 14; k++) begin
      step(1);
      exp_irq = (k % 3 == 0);
      exp_pwm = ((k / 3) % 2 == 1);
      checks++; if (irq !== exp_irq) begin errors++; $display("FAIL cont_irq k=%0d: got %b want %b", k, irq, exp_irq); end
      checks++; if (pwm !== exp_pwm) begin errors++; $display("FAIL cont_pwm k=%0d: got %b want %b", k, pwm, exp_pwm); end
    end
    ctrl = 16'h008D;
    step(1);
    ctrl = 16'h000D;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL clr_on_wrap_irq: got %b want 0", irq); end
    checks++; if (pwm !== 1'b0) begin errors++; $display("FAIL clr_on_wrap_pwm: got %b want 0", pwm); end
    step(3);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL after_clr_irq: got %b want 1", irq); end
    checks++; if (pwm !== 1'b1) begin errors++; $display("FAIL after_clr_pwm: got %b want 1", pwm); end
    step(1);
    ctrl = 16'h008D;
    step(1);
    ctrl = 16'h000D;
    step(1);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL clr_mid_restart_early_irq: got %b want 0", irq); end
    step(2);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL clr_mid_restart_irq: got %b want 1", irq); end
  endtask

  task automatic test_edges();
    int seen_irq, seen_pwm;
    go_idle();
    period = 16'd0; divisor = 16'd1; dc = 16'd1; ctrl = 16'h000B;
    seen_irq = 0; seen_pwm = 0;
    for (int k = 0; k < 10; k++) begin
      step(1);
      if (irq) seen_irq++;
      if (pwm) seen_pwm++;
    end
    checks++; if (seen_irq != 0 || seen_pwm != 0) begin
      errors++; $display("FAIL period0_idle: irq_cycles=%0d pwm_cycles=%0d want 0 0", seen_irq, seen_pwm);
    end
    go_idle();
    period = 16'd8; divisor = 16'd1; dc = 16'hFFFF; ctrl = 16'h0003;
    step(1);
    for (int k = 1; k <= 16; k++) begin
      step(1);
      checks++; if (pwm !== 1'b1) begin errors++; $display("FAIL dc_full k=%0d: got %b want 1", k, pwm); end
    end
    test_pwm_basic(16'd0);
    step(8);
    period = 16'd0;
    step(1);
    checks++; if (pwm !== 1'b0) begin errors++; $display("FAIL period0_run_pwm: got %b want 0", pwm); end
    seen_irq = 0;
    for (int k = 0; k < 6; k++) begin
      if (irq) seen_irq++;
      step(1);
    end
    checks++; if (seen_irq != 0) begin errors++; $display("FAIL period0_run_irq: irq_cycles=%0d want 0", seen_irq); end
  endtask

  initial begin
    test_reset();
    test_pwm_basic(16'd1);
    test_pwm_div3();
    test_oneshot();
    test_timer_cont();
    test_edges();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
